shift_unit_iter: RTL
====================

// Module: shift_unit_iter
// PURPOSE
//   Multi-mode, multi-cycle shifter for the ALU datapath: SRL, SLL, SRA and ROR
//   on a WIDTH-bit operand. The shift amount is consumed at most STEP bits per
//   clock, which trades latency for a small shift network.
//   Uses valid/ready handshakes on input and output so the control unit can
//   stall on it. Holds one operation at a time and does not overlap operations.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be >= 2
//   SHW    5   shift-amount width = $clog2(WIDTH); shift range is 0..WIDTH-1
//   STEP   4   maximum bit positions shifted per SHIFT cycle; 1 <= STEP <= WIDTH-1
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      A/shift/mode are valid this cycle
//   in_ready   out  1      unit can accept; high only in IDLE
//   A          in   WIDTH  operand
//   shift      in   SHW    shift amount
//   mode       in   2      00=SRL 01=SLL 10=SRA 11=ROR
//   out_valid  out  1      res holds a finished result
//   out_ready  in   1      consumer takes res this cycle
//   res        out  WIDTH  result; stable while out_valid=1
//   busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//   Reset, sampled at posedge when rst_n=0:
//     - state=IDLE; in_ready=1; out_valid=0; busy=0; res=0.
//     - Internal operand, remaining-count and mode registers are cleared.
//     - Reset in SHIFT or DONE drops the in-flight operation; no out_valid pulse follows.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE: in_ready=1. Accept on in_valid=1 at a posedge.
//       - Latch A into acc, shift into rem, and mode.
//       - Go to DONE if shift==0, else go to SHIFT.
//     SHIFT: in_ready=0. At each posedge:
//       - amt = min(rem, STEP).
//       - acc <= op(acc, amt), where op is one of:
//           SRL: zero-fill from MSB.
//           SLL: zero-fill from LSB.
//           SRA: fill with the original A[WIDTH-1], latched at accept.
//           ROR: bits leaving LSB re-enter at MSB.
//       - rem <= rem - amt.
//       - Go to DONE when rem - amt == 0.
//     DONE: out_valid=1; res=acc.
//       - out_ready=1 at a posedge: go to IDLE; out_valid falls after that edge.
//       - out_ready=0: hold res, out_valid and the state indefinitely.
//   Latency: n = ceil(shift/STEP). Count the accepting edge as edge 0.
//     - out_valid is high after edge n; for shift==0 it is high right after edge 0.
//   Results equal one-shot ops: A>>s, A<<s, $signed(A)>>>s, rotate-right by s.
//   Chunked SRA/ROR must match the one-shot result for every s.
//   No arithmetic carry. rem is never negative and never exceeds WIDTH-1.
//   Inputs are ignored outside IDLE. A/shift/mode may change after acceptance without effect.
//   Back-to-back: a new operation can be accepted in the cycle after DONE->IDLE.
//     - Minimum issue interval is n+2 cycles.
//   mode, A and shift are never used combinationally toward outputs.
//     - Every output is driven from a register.
// TESTING
//   1 SRL A=0x80000000, shift=31, STEP=4
//       -> n=8; out_valid after edge 8; res=0x00000001.
//   2 SRA A=0x80000000, shift=4 -> n=1; res=0xF8000000.
//     SRA A=0x7FFFFFF0, shift=4 -> res=0x07FFFFFF.
//   3 ROR A=0x12345678, shift=8 -> res=0x78123456.
//     SLL A=0x00000001, shift=31 -> res=0x80000000.
//   4 shift=0, A=0xDEADBEEF, any mode
//       -> out_valid in cycle after accept; res=0xDEADBEEF.
//   5 Backpressure: hold out_ready=0 for 5 cycles in DONE
//       -> res stable; in_ready=0; in_valid pulses ignored; then out_ready=1 -> IDLE.
//   6 rst_n=0 during 3rd SHIFT cycle
//       -> next cycle IDLE; out_valid=0; res=0; next accepted op completes correctly.

Source files
------------

// File: rtl/shift_unit_iter.sv
// Multi-cycle SRL/SLL/SRA/ROR shifter that consumes at most STEP bit positions
// per clock, with valid/ready handshakes on both sides.
module shift_unit_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SRL = 2'b00, OP_SLL = 2'b01,
                            OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;

  localparam logic [SHW-1:0] STEP_W  = SHW'(STEP);
  localparam logic [SHW:0]   WIDTH_W = (SHW+1)'(WIDTH);

  state_e           state_q;
  op_e              mode_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   rem_q;
  logic             sign_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] res_q;

  logic [SHW-1:0]   amt;
  logic [SHW:0]     inv_amt;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] acc_d;

  // One chunk of the shift; SRA fills from the sign latched at accept so the
  // chunked result matches a one-shot arithmetic shift.
  always_comb begin
    amt     = (rem_q > STEP_W) ? STEP_W : rem_q;
    inv_amt = WIDTH_W - {1'b0, amt};
    ones    = '1;
    acc_d   = acc_q;
    unique case (mode_q)
      OP_SRL: acc_d = acc_q >> amt;
      OP_SLL: acc_d = acc_q << amt;
      OP_SRA: acc_d = (acc_q >> amt) | (sign_q ? ~(ones >> amt) : '0);
      OP_ROR: acc_d = (acc_q >> amt) | (acc_q << inv_amt);
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= OP_SRL;
      acc_q       <= '0;
      rem_q       <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= A;
            rem_q      <= shift;
            mode_q     <= op_e'(mode);
            sign_q     <= A[WIDTH-1];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (shift == '0) begin
              state_q     <= DONE;
              res_q       <= A;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_q - amt;
          if (rem_q == amt) begin
            state_q     <= DONE;
            res_q       <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign res       = res_q;

endmodule
